// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single write port of the register file. After reset (or on a
// clear_req pulse) it sweeps zero into every register, then arbitrates
// between two writeback requesters (req0 = execute, req1 = memory).
//
// Handshake: a requester holds valid (with stable addr/data) until it sees
// ready high in the same cycle; valid & ready at a rising edge is a transfer.
// Ready depends combinationally on the valids, so valid must never depend
// on ready.
//
// Optional feature: define REGFILE_ARB_ROUND_ROBIN_EN to replace fixed
// priority (req0 wins) with round-robin arbitration on contention.
//
// dbg_state exposes the FSM state (0 = CLEAR, 1 = RUN) for checkers.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              dbg_state
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NREG - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_run;
    logic              w_xfer0;
    logic              w_xfer1;

    // State register; reset always restarts the sweep from register 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR after the last sweep write, enter it on clear_req.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_cnt == LAST_CNT) w_state_nxt = S_RUN;
            S_RUN:   if (clear_req)         w_state_nxt = S_CLEAR;
            default:                        w_state_nxt = S_CLEAR;
        endcase
    end

    // clear_req blocks both grants in the cycle it is seen, so no write
    // slips in ahead of the sweep.
    assign w_run = (r_state == S_RUN) && !clear_req;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    logic r_last;

    // On contention the requester that did not win last time is granted.
    always_comb begin
        req0_ready = w_run && (!req1_valid || r_last);
        req1_ready = w_run && (!req0_valid || !r_last);
    end

    // Remember which requester made the most recent transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b0;
        end else if (w_xfer0) begin
            r_last <= 1'b0;
        end else if (w_xfer1) begin
            r_last <= 1'b1;
        end
    end
`else
    // Fixed priority: execute writeback always beats memory writeback.
    always_comb begin
        req0_ready = w_run;
        req1_ready = w_run && !req0_valid;
    end
`endif

    assign w_xfer0 = req0_valid && req0_ready;
    assign w_xfer1 = req1_valid && req1_ready;

    // Registered write port: sweep writes in CLEAR, granted writes in RUN.
    // Writes to register 0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_CLEAR) begin
            r_we    <= 1'b1;
            r_addr  <= r_cnt;
            r_wdata <= '0;
            r_cnt   <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
            if (w_xfer0) begin
                r_we    <= (req0_addr != '0);
                r_addr  <= req0_addr;
                r_wdata <= req0_data;
            end else if (w_xfer1) begin
                r_we    <= (req1_addr != '0);
                r_addr  <= req1_addr;
                r_wdata <= req1_data;
            end else begin
                r_we <= 1'b0;
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_addr   = r_addr;
    assign rf_wdata  = r_wdata;
    assign busy      = (r_state == S_CLEAR);
    assign dbg_state = (r_state == S_RUN);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed test-plan sequences followed by
// random traffic, checked against a transaction-level reference model.
module tb_regfile_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;
    localparam int EW     = 1 + ADDR_W + DATA_W;

    logic              clk;
    logic              rst;
    logic              clear_req;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              busy;
    logic              dbg_state;

    regfile_write_arbiter #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NREG  (NREG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    bit monitor_on = 1'b1;

    // Reference model: port contents after each edge, sweep progress, RR pointer.
    bit                m_known    = 1'b0;
    bit                m_clearing = 1'b1;
    int                m_idx      = 0;
    bit                m_last     = 1'b0;
    logic [ADDR_W-1:0] m_addr     = '0;
    logic [DATA_W-1:0] m_data     = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Which requester wins given the valids and the previous winner (-1 = none).
    function automatic int pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
            return last ? 0 : 1;
`else
            return 0;
`endif
        end
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive inputs after the falling edge, check the combinational
    // outputs against the model, then predict the write port after the next
    // rising edge and push it to the scoreboard.
    task automatic drive(input bit r, input bit clr,
                         input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                         input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        bit e_r0;
        bit e_r1;
        int g;
        bit we;
        @(negedge clk);
        rst        = r;
        clear_req  = clr;
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        #1;
        e_r0 = m_known && !m_clearing && !clr && (pick(1'b1, v1, m_last) == 0);
        e_r1 = m_known && !m_clearing && !clr && (pick(v0, 1'b1, m_last) == 1);
        if (m_known) begin
            chk("busy", 64'(busy), 64'(m_clearing));
            chk("dbg_state", 64'(dbg_state), 64'(!m_clearing));
            chk("req0_ready", 64'(req0_ready), 64'(e_r0));
            chk("req1_ready", 64'(req1_ready), 64'(e_r1));
        end
        we = 1'b0;
        if (r) begin
            m_known    = 1'b1;
            m_clearing = 1'b1;
            m_idx      = 0;
            m_last     = 1'b0;
            m_addr     = '0;
            m_data     = '0;
        end else if (m_known && m_clearing) begin
            we     = 1'b1;
            m_addr = ADDR_W'(m_idx);
            m_data = '0;
            m_idx++;
            if (m_idx == NREG) begin
                m_clearing = 1'b0;
                m_idx      = 0;
            end
        end else if (m_known) begin
            g = -1;
            if (v0 && e_r0) g = 0;
            else if (v1 && e_r1) g = 1;
            if (g == 0) begin
                m_addr = a0; m_data = d0; we = (a0 != 0); m_last = 1'b0;
            end else if (g == 1) begin
                m_addr = a1; m_data = d1; we = (a1 != 0); m_last = 1'b1;
            end
            if (clr) begin
                m_clearing = 1'b1;
                m_idx      = 0;
            end
        end
        if (m_known) exp_q.push_back({we, m_addr, m_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // ---------------- monitor ----------------
    // Every rising edge produces one new write-port value; compare it with
    // the oldest prediction.
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (monitor_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_port", 64'({rf_we, rf_addr, rf_wdata}), 64'(e));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; clear_req = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // Reset for two cycles, then the full sweep plus a margin.
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(NREG + 2);

        // Single write to r5.
        drive(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle(2);

        // Contention for three cycles, then req1 alone.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd2, 32'h22);
        idle(1);

        // Continuous contention (alternates when round robin is built in).
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);

        // Write to x0 is accepted but dropped.
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
        idle(1);

        // clear_req with req0 valid, then req0 holds through the sweep.
        drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
        for (int i = 0; i < NREG + 1; i++) drive(1'b0, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
        idle(1);

        // Reset in the middle of a sweep restarts it from register 0.
        drive(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(10);
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        idle(NREG + 2);

        // Random traffic, with occasional clears, resets and x0 writes.
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit c;
            logic [ADDR_W-1:0] a0;
            logic [ADDR_W-1:0] a1;
            r  = ($urandom_range(0, 149) == 0);
            c  = ($urandom_range(0, 39) == 0);
            a0 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, 31));
            drive(r, c, 1'($urandom_range(0, 1)), a0, $urandom,
                        1'($urandom_range(0, 1)), a1, $urandom);
        end

        // Drain: the final prediction is compared on the next edge.
        @(posedge clk);
        #3;
        monitor_on = 1'b0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 32x32 register file: drives its write-enable, write-address and write-data inputs.
- Shares that port between two writeback requesters (req0 = ALU/execute, req1 = load/memory) using a valid/ready handshake.
- After reset, or on request, runs a clear sequence that writes zero to every register before accepting traffic.
- Sits between the execute/memory writeback paths and the register file, at the CPU core top level.

Parameters:
- DATA_W, 32, data width of the write port.
- ADDR_W, 5, register address width.
- NREG, 32, number of registers swept by the clear sequence (must be <= 2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear_req  input  1  one-cycle pulse in RUN starts a new clear sweep.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  ADDR_W  requester 0 destination register.
- req0_data  input  DATA_W  requester 0 write data.
- req0_ready  output  1  requester 0 write accepted this cycle (when valid).
- req1_valid  input  1  requester 1 has a write pending.
- req1_addr  input  ADDR_W  requester 1 destination register.
- req1_data  input  DATA_W  requester 1 write data.
- req1_ready  output  1  requester 1 write accepted this cycle (when valid).
- rf_we  output  1  register-file write enable (registered).
- rf_addr  output  ADDR_W  register-file write address (registered).
- rf_wdata  output  DATA_W  register-file write data (registered).
- busy  output  1  high while the clear sweep is in progress.

Behaviour:
- FSM states: CLEAR, RUN.
- rst=1 at an edge:
  - state<=CLEAR, cnt<=0, rf_we<=0, rf_addr<=0, rf_wdata<=0.
  - Round-robin pointer (if compiled in) <=0.
  - This overrides everything, including a sweep or write in progress.
- busy = (state==CLEAR), combinational; it is 1 during reset.
- CLEAR, each cycle with rst=0:
  - rf_we<=1, rf_addr<=cnt, rf_wdata<=0, cnt<=cnt+1.
  - When cnt==NREG-1, that final write is issued, then state<=RUN and cnt<=0.
  - The sweep takes exactly NREG cycles; the first clear write is visible at the edge after rst falls.
- In CLEAR, req0_ready=req1_ready=0 and clear_req is ignored.
- RUN, arbitration (combinational):
  - Fixed priority: req0_ready = RUN; req1_ready = RUN & ~req0_valid.
  - A transfer happens when valid & ready are both 1.
- RUN, write issue (registered):
  - On a transfer: rf_we<=1, rf_addr<=addr, rf_wdata<=data.
  - If the transfer address is 0, the write is accepted (ready=1) but dropped: rf_we<=0.
  - With no transfer: rf_we<=0; rf_addr and rf_wdata hold their values.
  - Latency: transfer at edge N produces rf_we=1 during cycle N+1, and the register file captures it at edge N+1.
  - Throughput: 1 write per cycle; the losing requester holds valid and retries.
- clear_req=1 in RUN:
  - The same cycle, both readys are forced to 0, so no transfer happens.
  - Next state is CLEAR with cnt=0.
  - A write issued on the previous edge still completes normally (rf_we is already registered).
- Simultaneous clear_req and valid: clear_req wins; the requester is not accepted and must hold its request.
- rst and clear_req together: rst wins (same result, CLEAR from 0).
- Readys depend combinationally on the valids. Requesters must not make valid depend on ready.

Optional Feature:
- Macro: REGFILE_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit pointer `last` records the requester of the most recent transfer.
  - When both valids are high, the requester with id != last is granted.
  - When only one is valid, it is granted.
  - `last` updates only on a transfer and resets to 0, so req1 wins the first contention.
- Undefined: fixed priority, req0 always wins; no pointer flop exists.

Test Plan:
- Clear sweep: hold rst=1 for 2 cycles, release → busy=1 and rf_we=1 for exactly 32 cycles with rf_addr 0..31 and rf_wdata=0; then busy=0, rf_we=0, readys go high.
- Single write: in RUN, req0 valid, addr=5, data=0xDEADBEEF for 1 cycle → req0_ready=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- Contention, fixed priority: both valid for 3 cycles (req0 addr 1 data 0x11, req1 addr 2 data 0x22) → req1_ready=0 throughout, three writes to addr 1; req1 is accepted once req0 drops.
- Contention, round robin (macro defined): both valid continuously → grants alternate req1, req0, req1, req0; rf_addr sequence is 2,1,2,1.
- x0 drop: req1 valid, addr=0, data=0xFFFFFFFF → req1_ready=1; next cycle rf_we=0.
- Mid-run clear and reset: pulse clear_req with req0 valid → req0_ready=0 that cycle, then a 32-cycle sweep and req0 accepted after. Assert rst at sweep cycle 10 → the sweep restarts from addr 0 and still takes 32 cycles.
